stopwatch_display: RTL
======================

Name: stopwatch_display

Overview:
- Downstream consumer of the stopwatch counter. Takes its binary minute (0-3) and second (0-63) outputs and drives a 4-digit multiplexed 7-segment display in M.SS format.
- Converts seconds to BCD with an iterative shift-add-3 (double-dabble) FSM.
- Updates display digits atomically and time-multiplexes the anodes.

Parameters:
- SCAN_DIV, 1000: clk cycles each digit stays lit; legal range 2..65535.
- SEG_ACTIVE_LOW, 1: 1 = seg/dp/an outputs active-low; 0 = active-high.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- minute  input  2  binary minutes from stopwatch.
- second  input  6  binary seconds from stopwatch.
- blank  input  1  1 = all digits dark; scanning continues.
- seg  output  7  segments, bit order {g,f,e,d,c,b,a}.
- dp  output  1  decimal point of the currently lit digit.
- an  output  4  digit enables, one-hot; an[0] = rightmost digit.

Behaviour:
- Reset state (reset=0, takes effect immediately, no clock needed):
  - Outputs: an all off, seg all off, dp off (1111 / 7'h7F / 1 when SEG_ACTIVE_LOW=1).
  - Internals: FSM IDLE, last-captured value 0, display digits {m,st,so}=0,0,0, scan counter 0, digit index 0.
- Converter FSM states are IDLE, SHIFT, DONE.
- IDLE: at each edge, compare {minute,second} with the last-captured value. If different, capture both, load the shift register (BCD 8 bits = 0, binary = second), clear the iteration count and go to SHIFT. Otherwise stay in IDLE.
- SHIFT: each edge first adds 3 to every BCD nibble >=5, then shifts {bcd,bin} left by 1. After the 6th shift, go to DONE.
- DONE: at one edge, write m=captured minute, st=tens nibble, so=ones nibble, all together, then return to IDLE.
- Latency: input sampled at edge N, shifts at N+1..N+6, display digits valid after edge N+7. The earliest next capture is edge N+8.
- Input changes during SHIFT/DONE are not captured. IDLE recompares afterwards, so only the newest value is converted and intermediate values may be skipped.
- Seconds 60-63 are converted as-is and shown as 6,0..6,3; there is no clamping.
- Scan counter:
  - Counts 0..SCAN_DIV-1 and wraps.
  - On wrap, the digit index advances 0,1,2,3,0.
  - The index does not advance on the wrap cycle after reset; the first wrap is SCAN_DIV cycles after release.
- Digit mapping:
  - Index 0 shows so.
  - Index 1 shows st.
  - Index 2 shows m with dp lit.
  - Index 3 is always dark: an bit inactive, seg off.
- Output register: seg/an/dp are registered and reflect the digit index and display digits one cycle after they change. There are no glitches and exactly one an bit is active, except when the slot is dark.
- blank=1: from the next edge an is all inactive, seg off, dp off. The scan counter and converter keep running. blank=0 resumes on the next edge at the current index.
- Reset mid-conversion aborts the conversion; the display returns to 0.00. After release, a nonzero input triggers a fresh conversion.
- Any nibble >9 (unreachable) decodes to all segments off.

Decomposition:
- Package stopwatch_display_pkg:
  - Segment code constants SEG_0..SEG_9 (active-high: 0=7'b0111111, 1=7'b0000110, 2=7'b1011011, 3=7'b1001111, 4=7'b1100110, 5=7'b1101101, 6=7'b1111101, 7=7'b0000111, 8=7'b1111111, 9=7'b1101111) and SEG_OFF=7'b0000000.
  - FSM state encoding.
  - Digit index constants.
- One sub-module: bin2bcd_seq, the 6-bit double-dabble FSM with a start/done handshake. Scan and decode logic stay in the top level.

Test Plan:
- Reset: hold reset=0 with minute=2, second=33 -> an=4'b1111, seg=7'h7F immediately. After release, digits convert to 2,3,3 at edge 7. With SCAN_DIV=4, scan shows an=1110/seg=~SEG_3, then 1101/~SEG_3, then 1011/~SEG_2 with dp=0, then 1111.
- Conversion latency: in IDLE, change to minute=1, second=47 before edge N -> digits 1,4,7 after edge N+7 and unchanged at N+6. Repeat for second=59 (5,9), 0 (0,0) and 63 (6,3).
- Change during conversion: 0:12 sampled at edge N, 0:13 applied at N+2 -> digits 0,1,2 at N+7 and 0,1,3 at N+15. Inputs 0:13, 0:14, 0:15 applied inside one conversion window -> only 0:15 is displayed next.
- Blank: blank=1 mid-scan -> an=1111 at the next edge. Release after 10 cycles -> the index resumes as if never blanked (index derived from 10 cycles of scan counting).
- Reset mid-conversion: assert reset at N+3 -> outputs dark immediately. After release, digits reach the current input within 8 cycles.
- SEG_ACTIVE_LOW=0 build: digit 8 lit -> seg=7'b1111111 and an is an active-high one-hot.

Source files
------------

// File: rtl/stopwatch_display_pkg.sv
// Shared constants for the stopwatch display: segment codes, converter
// state encoding and digit slot numbering.
package stopwatch_display_pkg;

  // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0   = 7'b0111111;
  localparam logic [6:0] SEG_1   = 7'b0000110;
  localparam logic [6:0] SEG_2   = 7'b1011011;
  localparam logic [6:0] SEG_3   = 7'b1001111;
  localparam logic [6:0] SEG_4   = 7'b1100110;
  localparam logic [6:0] SEG_5   = 7'b1101101;
  localparam logic [6:0] SEG_6   = 7'b1111101;
  localparam logic [6:0] SEG_7   = 7'b0000111;
  localparam logic [6:0] SEG_8   = 7'b1111111;
  localparam logic [6:0] SEG_9   = 7'b1101111;
  localparam logic [6:0] SEG_OFF = 7'b0000000;

  // Binary-to-BCD converter states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  // Number of shift steps for a 6-bit binary input
  localparam int BCD_SHIFTS = 6;

  // Digit slots of the scan, slot 0 is the rightmost digit
  localparam logic [1:0] DIG_ONES = 2'd0;
  localparam logic [1:0] DIG_TENS = 2'd1;
  localparam logic [1:0] DIG_MIN  = 2'd2;
  localparam logic [1:0] DIG_DARK = 2'd3;

  // BCD nibble to active-high segments; out-of-range nibbles stay dark
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 6-bit double-dabble converter with a start/done handshake.
// One shift per clock; done pulses for one cycle while the result is held.
module bin2bcd_seq
  import stopwatch_display_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] bin,
  output logic       ready,
  output logic       done,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  conv_state_t state_reg, state_next;
  logic [13:0] sh_reg, sh_next;   // {tens, ones, binary}
  logic [2:0]  cnt_reg, cnt_next;
  logic [7:0]  bcd_adj;

  // Add-3 correction on every BCD nibble that is 5 or more
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (sh_reg[6 + gi*4 +: 4] >= 4'd5)
                                ? sh_reg[6 + gi*4 +: 4] + 4'd3
                                : sh_reg[6 + gi*4 +: 4];
    end
  endgenerate

  // State, shift register and iteration counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      sh_reg    <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      sh_reg    <= sh_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic: load on start, six adjust-and-shift steps, then done
  always_comb begin
    state_next = state_reg;
    sh_next    = sh_reg;
    cnt_next   = cnt_reg;
    ready      = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          sh_next    = {8'h00, bin};
          cnt_next   = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        sh_next  = {bcd_adj[6:0], sh_reg[5:0], 1'b0};
        cnt_next = cnt_reg + 3'd1;
        if (cnt_reg == 3'(BCD_SHIFTS - 1)) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign tens = sh_reg[13:10];
  assign ones = sh_reg[9:6];

endmodule

// File: rtl/stopwatch_display.sv
// M.SS multiplexed 7-segment driver fed by the stopwatch counter.
// Captures changed time values, converts seconds to BCD, commits all three
// digits together and scans them onto a registered 4-digit display.
module stopwatch_display
  import stopwatch_display_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] minute,
  input  logic [5:0] second,
  input  logic       blank,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam logic        POL       = (SEG_ACTIVE_LOW != 0);
  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

  logic [7:0]  last_reg;           // last captured {minute, second}
  logic [1:0]  m_reg;
  logic [3:0]  st_reg, so_reg;
  logic [15:0] scan_cnt_reg;
  logic [1:0]  idx_reg;

  logic        conv_ready, conv_done, conv_start;
  logic [3:0]  conv_tens, conv_ones;
  logic [3:0]  digit_val;
  logic        lit, dp_on;
  logic [6:0]  seg_on;
  logic [3:0]  an_on;

  // A new conversion starts only when the converter is idle and the time moved
  assign conv_start = conv_ready && ({minute, second} != last_reg);

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (conv_start),
    .bin   (second),
    .ready (conv_ready),
    .done  (conv_done),
    .tens  (conv_tens),
    .ones  (conv_ones)
  );

  // Capture the time value being converted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          last_reg <= '0;
    else if (conv_start) last_reg <= {minute, second};
  end

  // Commit all display digits in the same cycle so the display never tears
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_reg  <= '0;
      st_reg <= '0;
      so_reg <= '0;
    end else if (conv_done) begin
      m_reg  <= last_reg[7:6];
      st_reg <= conv_tens;
      so_reg <= conv_ones;
    end
  end

  // Scan prescaler and digit index; blank does not pause the scan
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt_reg <= '0;
      idx_reg      <= DIG_ONES;
    end else if (scan_cnt_reg == SCAN_LAST) begin
      scan_cnt_reg <= '0;
      idx_reg      <= idx_reg + 2'd1;
    end else begin
      scan_cnt_reg <= scan_cnt_reg + 16'd1;
    end
  end

  // Select the digit for the current slot; slot 3 and blank stay dark
  always_comb begin
    digit_val = 4'hF;
    lit       = 1'b0;
    dp_on     = 1'b0;
    case (idx_reg)
      DIG_ONES: begin digit_val = so_reg; lit = 1'b1; end
      DIG_TENS: begin digit_val = st_reg; lit = 1'b1; end
      DIG_MIN:  begin digit_val = {2'b00, m_reg}; lit = 1'b1; dp_on = 1'b1; end
      DIG_DARK: lit = 1'b0;
      default:  lit = 1'b0;
    endcase
    if (blank) begin
      lit   = 1'b0;
      dp_on = 1'b0;
    end
    seg_on = lit ? seg_decode(digit_val) : SEG_OFF;
  end

  // One-hot digit enable for the lit slot
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_an
      assign an_on[gi] = lit && (idx_reg == 2'(gi));
    end
  endgenerate

  // Registered, polarity-adjusted display drive
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg <= {7{POL}};
      dp  <= POL;
      an  <= {4{POL}};
    end else begin
      seg <= seg_on ^ {7{POL}};
      dp  <= dp_on ^ POL;
      an  <= an_on ^ {4{POL}};
    end
  end

endmodule
